csr_dosyasi: RTL and testbench

CSR_DOSYASI -- requirements
Module: csr_dosyasi

---
 rtl/csr_dosyasi.sv | 198 +++++++++++++++++++
 tb/tb_csr_dosyasi.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_dosyasi.sv
`default_nettype none
// ============================================================================
// Module  : csr_dosyasi
// Brief   : Machine-mode CSR file with trap entry/return and cycle/instret counters.
// Revision: 1.0 - initial release
// ============================================================================
module csr_dosyasi #(
    parameter int unsigned SAYAC_W   = 64,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0100,
    parameter logic [31:0] HART_ID   = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        basla_i,
    input  logic [2:0]  kontrol_i,
    input  logic [11:0] adr_i,
    input  logic [31:0] deger_i,
    input  logic [4:0]  zimm_i,
    input  logic        kaynak_sifir_i,
    input  logic [30:0] ps_i,
    input  logic        exception_i,
    input  logic [3:0]  mcause_i,
    input  logic        mret_i,
    input  logic        instret_i,
    output logic [31:0] sonuc_o,
    output logic        gecerli_o,
    output logic        illegal_o,
    output logic        yonlendir_o,
    output logic [31:0] hedef_ps_o
);

    localparam logic [11:0] c_MSTATUS   = 12'h300;
    localparam logic [11:0] c_MTVEC     = 12'h305;
    localparam logic [11:0] c_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_MEPC      = 12'h341;
    localparam logic [11:0] c_MCAUSE    = 12'h342;
    localparam logic [11:0] c_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_MHARTID   = 12'hF14;

    localparam logic [1:0] c_OP_RW = 2'b01;
    localparam logic [1:0] c_OP_RS = 2'b10;
    localparam logic [1:0] c_OP_RC = 2'b11;

    localparam bit c_HAS_HI = (SAYAC_W == 64);

    logic               r_mie;
    logic               r_mpie;
    logic [31:2]        r_mtvec;
    logic [31:0]        r_mscratch;
    logic [31:1]        r_mepc;
    logic [3:0]         r_mcause;
    logic [SAYAC_W-1:0] r_mcycle;
    logic [SAYAC_W-1:0] r_minstret;

    logic [31:0] r_sonuc;
    logic        r_gecerli;
    logic        r_illegal;
    logic        r_yonlendir;
    logic [31:0] r_hedef;

    logic [63:0] w_mcycle64;
    logic [63:0] w_minstret64;
    logic [63:0] w_cyc_nxt;
    logic [63:0] w_ins_nxt;
    logic [31:0] w_rdata;
    logic        w_impl;
    logic        w_op_ok;
    logic [31:0] w_src;
    logic        w_src_zero;
    logic        w_yazar;
    logic [31:0] w_yeni;
    logic        w_illegal;
    logic        w_we;

    // Counters are viewed as 64 bits so the high halves read 0 when SAYAC_W is 32.
    assign w_mcycle64   = 64'(r_mcycle);
    assign w_minstret64 = 64'(r_minstret);

    always_comb begin
        w_rdata = '0;
        w_impl  = 1'b1;
        case (adr_i)
            c_MSTATUS:   w_rdata = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
            c_MTVEC:     w_rdata = {r_mtvec, 2'b00};
            c_MSCRATCH:  w_rdata = r_mscratch;
            c_MEPC:      w_rdata = {r_mepc, 1'b0};
            c_MCAUSE:    w_rdata = {28'b0, r_mcause};
            c_MCYCLE:    w_rdata = w_mcycle64[31:0];
            c_MINSTRET:  w_rdata = w_minstret64[31:0];
            c_MCYCLEH:   w_rdata = w_mcycle64[63:32];
            c_MINSTRETH: w_rdata = w_minstret64[63:32];
            c_MHARTID:   w_rdata = HART_ID;
            default:     w_impl  = 1'b0;
        endcase
    end

    assign w_op_ok    = basla_i && (kontrol_i != 3'b000) && !exception_i && !mret_i;
    assign w_src      = kontrol_i[2] ? {27'b0, zimm_i} : deger_i;
    assign w_src_zero = kontrol_i[2] ? (zimm_i == 5'd0) : kaynak_sifir_i;

    always_comb begin
        w_yazar = 1'b0;
        w_yeni  = w_rdata;
        case (kontrol_i[1:0])
            c_OP_RW: begin
                w_yazar = 1'b1;
                w_yeni  = w_src;
            end
            c_OP_RS: begin
                w_yazar = !w_src_zero;
                w_yeni  = w_rdata | w_src;
            end
            c_OP_RC: begin
                w_yazar = !w_src_zero;
                w_yeni  = w_rdata & ~w_src;
            end
            default: ;
        endcase
    end

    assign w_illegal = !w_impl || ((adr_i == c_MHARTID) && w_yazar);
    assign w_we      = w_op_ok && w_yazar && !w_illegal;

    // A written half replaces the increment outright; the other half holds.
    always_comb begin
        w_cyc_nxt = w_mcycle64 + 64'd1;
        w_ins_nxt = w_minstret64 + {63'd0, instret_i};
        if (w_we) begin
            case (adr_i)
                c_MCYCLE:    w_cyc_nxt = {w_mcycle64[63:32], w_yeni};
                c_MINSTRET:  w_ins_nxt = {w_minstret64[63:32], w_yeni};
                c_MCYCLEH:   if (c_HAS_HI) w_cyc_nxt = {w_yeni, w_mcycle64[31:0]};
                c_MINSTRETH: if (c_HAS_HI) w_ins_nxt = {w_yeni, w_minstret64[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mie       <= 1'b0;
            r_mpie      <= 1'b0;
            r_mtvec     <= MTVEC_RST[31:2];
            r_mscratch  <= '0;
            r_mepc      <= '0;
            r_mcause    <= '0;
            r_mcycle    <= '0;
            r_minstret  <= '0;
            r_sonuc     <= '0;
            r_gecerli   <= 1'b0;
            r_illegal   <= 1'b0;
            r_yonlendir <= 1'b0;
            r_hedef     <= '0;
        end else begin
            r_mcycle    <= w_cyc_nxt[SAYAC_W-1:0];
            r_minstret  <= w_ins_nxt[SAYAC_W-1:0];
            r_gecerli   <= w_op_ok;
            r_illegal   <= w_op_ok && w_illegal;
            r_sonuc     <= (w_op_ok && !w_illegal) ? w_rdata : 32'd0;
            r_yonlendir <= exception_i || mret_i;
            r_hedef     <= '0;
            if (exception_i) begin
                r_mepc   <= ps_i;
                r_mcause <= mcause_i;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
                r_hedef  <= {r_mtvec, 2'b00};
            end else if (mret_i) begin
                r_mie   <= r_mpie;
                r_mpie  <= 1'b1;
                r_hedef <= {r_mepc, 1'b0};
            end else if (w_we) begin
                case (adr_i)
                    c_MSTATUS: begin
                        r_mie  <= w_yeni[3];
                        r_mpie <= w_yeni[7];
                    end
                    c_MTVEC:    r_mtvec    <= w_yeni[31:2];
                    c_MSCRATCH: r_mscratch <= w_yeni;
                    c_MEPC:     r_mepc     <= w_yeni[31:1];
                    c_MCAUSE:   r_mcause   <= w_yeni[3:0];
                    default: ;
                endcase
            end
        end
    end

    assign sonuc_o     = r_sonuc;
    assign gecerli_o   = r_gecerli;
    assign illegal_o   = r_illegal;
    assign yonlendir_o = r_yonlendir;
    assign hedef_ps_o  = r_hedef;

endmodule
`default_nettype wire

// File: tb/tb_csr_dosyasi.sv
`default_nettype none
// ============================================================================
// Module  : tb_csr_dosyasi
// Brief   : Self-checking bench for csr_dosyasi against a behavioural CSR model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_csr_dosyasi;

    localparam logic [31:0] c_HART  = 32'h0000_0007;
    localparam logic [31:0] c_MTVEC = 32'h0000_0103;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        basla = 1'b0;
    logic [2:0]  kontrol = '0;
    logic [11:0] adr = '0;
    logic [31:0] deger = '0;
    logic [4:0]  zimm = '0;
    logic        ks0 = 1'b0;
    logic [30:0] ps = '0;
    logic        exc = 1'b0;
    logic [3:0]  mcause_in = '0;
    logic        mret = 1'b0;
    logic        instret = 1'b0;
    logic [31:0] sonuc;
    logic        gecerli;
    logic        illegal;
    logic        yon;
    logic [31:0] hedef;

    csr_dosyasi #(
        .SAYAC_W   (64),
        .MTVEC_RST (c_MTVEC),
        .HART_ID   (c_HART)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .basla_i        (basla),
        .kontrol_i      (kontrol),
        .adr_i          (adr),
        .deger_i        (deger),
        .zimm_i         (zimm),
        .kaynak_sifir_i (ks0),
        .ps_i           (ps),
        .exception_i    (exc),
        .mcause_i       (mcause_in),
        .mret_i         (mret),
        .instret_i      (instret),
        .sonuc_o        (sonuc),
        .gecerli_o      (gecerli),
        .illegal_o      (illegal),
        .yonlendir_o    (yon),
        .hedef_ps_o     (hedef)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural state of the model, stored as the values software would read.
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins;
    logic [31:0] e_sonuc = '0, e_hedef = '0;
    bit          e_val = 0, e_ill = 0, e_yon = 0;

    function automatic logic [31:0] m_read(input logic [11:0] a, output bit impl);
        impl = 1'b1;
        case (a)
            12'h300: m_read = 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h305: m_read = m_mtvec;
            12'h340: m_read = m_mscratch;
            12'h341: m_read = m_mepc;
            12'h342: m_read = m_mcause;
            12'hB00: m_read = m_cyc[31:0];
            12'hB02: m_read = m_ins[31:0];
            12'hB80: m_read = m_cyc[63:32];
            12'hB82: m_read = m_ins[63:32];
            12'hF14: m_read = c_HART;
            default: begin
                impl   = 1'b0;
                m_read = 32'd0;
            end
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] old, src, nv;
        logic [63:0] cn, inn;
        bit impl, wr;
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_mtvec = c_MTVEC & ~32'd3;
            m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
            e_val = 0; e_ill = 0; e_yon = 0; e_sonuc = 0; e_hedef = 0;
            return;
        end
        e_val = 0; e_ill = 0; e_yon = 0; e_sonuc = 0; e_hedef = 0;
        cn  = m_cyc + 64'd1;
        inn = m_ins + (instret ? 64'd1 : 64'd0);
        if (exc) begin
            e_yon = 1; e_hedef = m_mtvec;
            m_mepc = {ps, 1'b0}; m_mcause = {28'd0, mcause_in};
            m_mpie = m_mie; m_mie = 0;
        end else if (mret) begin
            e_yon = 1; e_hedef = m_mepc;
            m_mie = m_mpie; m_mpie = 1;
        end else if (basla && kontrol != 3'b000) begin
            e_val = 1;
            old = m_read(adr, impl);
            src = kontrol[2] ? {27'd0, zimm} : deger;
            wr  = 0; nv = old;
            if (kontrol[1:0] == 2'b01) begin wr = 1; nv = src; end
            if (kontrol[1:0] == 2'b10) begin wr = kontrol[2] ? (zimm != 0) : !ks0; nv = old | src; end
            if (kontrol[1:0] == 2'b11) begin wr = kontrol[2] ? (zimm != 0) : !ks0; nv = old & ~src; end
            if (!impl || (adr == 12'hF14 && wr)) begin
                e_ill = 1;
            end else begin
                e_sonuc = old;
                if (wr) begin
                    case (adr)
                        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                        12'h305: m_mtvec = nv & ~32'd3;
                        12'h340: m_mscratch = nv;
                        12'h341: m_mepc = nv & ~32'd1;
                        12'h342: m_mcause = nv & 32'hF;
                        12'hB00: cn  = {m_cyc[63:32], nv};
                        12'hB80: cn  = {nv, m_cyc[31:0]};
                        12'hB02: inn = {m_ins[63:32], nv};
                        12'hB82: inn = {nv, m_ins[31:0]};
                        default: ;
                    endcase
                end
            end
        end
        m_cyc = cn;
        m_ins = inn;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("gecerli", 32'(gecerli), 32'(e_val));
            chk("illegal", 32'(illegal), 32'(e_ill));
            chk("sonuc", sonuc, e_sonuc);
            chk("yonlendir", 32'(yon), 32'(e_yon));
            chk("hedef", hedef, e_hedef);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        basla = 0; kontrol = 0; adr = 0; deger = 0; zimm = 0; ks0 = 0;
        exc = 0; mret = 0; ps = 0; mcause_in = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op(input logic [2:0] k, input logic [11:0] a, input logic [31:0] d,
                      input logic [4:0] z, input bit s0);
        idle();
        basla = 1; kontrol = k; adr = a; deger = d; zimm = z; ks0 = s0;
        step();
    endtask

    task automatic rd(input logic [11:0] a);
        op(3'b010, a, 32'h0, 5'd0, 1'b1);
    endtask

    logic [11:0] addrs [14] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02,
                                12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h301, 12'hB01, 12'h000};
    logic [2:0]  ops   [7]  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_sonuc", sonuc, 32'h0);
        chk("rst_yon", 32'(yon), 32'h0);
        rst = 0;

        rd(12'h305); chk("mtvec_rst", sonuc, 32'h0000_0100);
        rd(12'h300); chk("mstatus_rst", sonuc, 32'h0000_1800);
        rd(12'hF14); chk("mhartid", sonuc, 32'h7);

        op(3'b001, 12'h340, 32'hDEADBEEF, 5'd0, 1'b0); chk("rw_old", sonuc, 32'h0);
        op(3'b010, 12'h340, 32'hFFFF0000, 5'd0, 1'b1); chk("rs_x0_read", sonuc, 32'hDEADBEEF);
        rd(12'h340); chk("mscratch_kept", sonuc, 32'hDEADBEEF);

        op(3'b110, 12'h300, 32'h0, 5'd8, 1'b0); chk("csrrsi_old", sonuc, 32'h1800);
        op(3'b111, 12'h300, 32'h0, 5'd8, 1'b0); chk("csrrci_old", sonuc, 32'h1808);
        rd(12'h300); chk("csrrci_new", sonuc, 32'h1800);

        op(3'b110, 12'h300, 32'h0, 5'd8, 1'b0);
        idle();
        exc = 1; ps = 31'h40; mcause_in = 4'd2; mret = 1;
        basla = 1; kontrol = 3'b001; adr = 12'h340; deger = 32'h0;
        step();
        chk("trap_yon", 32'(yon), 32'h1);
        chk("trap_hedef", hedef, 32'h100);
        chk("trap_no_op", 32'(gecerli), 32'h0);
        rd(12'h341); chk("trap_mepc", sonuc, 32'h80); chk("yon_pulse", 32'(yon), 32'h0);
        rd(12'h342); chk("trap_mcause", sonuc, 32'h2);
        rd(12'h340); chk("trap_op_dropped", sonuc, 32'hDEADBEEF);
        rd(12'h300); chk("trap_mstatus", sonuc, 32'h1880);
        idle(); mret = 1; step();
        chk("mret_yon", 32'(yon), 32'h1);
        chk("mret_hedef", hedef, 32'h80);
        rd(12'h300); chk("mret_mstatus", sonuc, 32'h1888); chk("hedef_idle", hedef, 32'h0);

        op(3'b001, 12'hB00, 32'hFFFFFFFF, 5'd0, 1'b0);
        op(3'b001, 12'hB80, 32'hFFFFFFFF, 5'd0, 1'b0);
        idle(); step();
        rd(12'hB00); chk("mcycle_wrap", sonuc, 32'h0);
        rd(12'hB80); chk("mcycleh_wrap", sonuc, 32'h0);

        op(3'b001, 12'hF14, 32'h55, 5'd0, 1'b0);
        chk("ill_hartid_flag", 32'(illegal), 32'h1); chk("ill_hartid_sonuc", sonuc, 32'h0);
        rd(12'h7C0);
        chk("ill_adr_flag", 32'(illegal), 32'h1); chk("ill_adr_sonuc", sonuc, 32'h0);
        rd(12'hF14); chk("hartid_kept", sonuc, 32'h7); chk("hartid_legal", 32'(illegal), 32'h0);

        op(3'b001, 12'h340, 32'h12345678, 5'd0, 1'b0);
        rst = 1;
        op(3'b001, 12'h305, 32'hAAAA0000, 5'd0, 1'b0);
        chk("rstop_gecerli", 32'(gecerli), 32'h0);
        chk("rstop_sonuc", sonuc, 32'h0);
        rst = 0;
        rd(12'hB00); chk("rstop_mcycle", sonuc, 32'h0);
        rd(12'h340); chk("rstop_mscratch", sonuc, 32'h0);
        rd(12'h305); chk("rstop_mtvec", sonuc, 32'h100);
        rd(12'h341); chk("rstop_mepc", sonuc, 32'h0);
        rd(12'h300); chk("rstop_mstatus", sonuc, 32'h1800);

        for (int i = 0; i < 3000; i++) begin
            basla     = ($urandom_range(0, 3) != 0);
            kontrol   = ops[$urandom_range(0, 6)];
            adr       = addrs[$urandom_range(0, 13)];
            deger     = $urandom();
            zimm      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom());
            ks0       = ($urandom_range(0, 3) == 0);
            ps        = 31'($urandom());
            mcause_in = 4'($urandom());
            exc       = ($urandom_range(0, 15) == 0);
            mret      = ($urandom_range(0, 15) == 0);
            instret   = 1'($urandom());
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0; instret = 0;
        idle(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
